// File: rtl/fp16_stream_accum.sv
// Streaming FP16 packet accumulator: one element per cycle in, one sum per packet out.
// Includes the combinational fp_adder it feeds (running sum + staged operand).

module fp_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] res
);
  logic        swap, s_big, s_sml;
  logic [4:0]  e_big, e_sml, d, e_r;
  logic [13:0] m_big, m_sml, m_sh, diff, norm;
  logic [14:0] sum;
  logic [3:0]  lz;
  logic        found;

  // Operands are always normal; the larger magnitude sets sign and base exponent.
  assign swap  = b[14:0] > a[14:0];
  assign s_big = swap ? b[15] : a[15];
  assign s_sml = swap ? a[15] : b[15];
  assign e_big = swap ? b[14:10] : a[14:10];
  assign e_sml = swap ? a[14:10] : b[14:10];
  assign m_big = {1'b1, (swap ? b[9:0] : a[9:0]), 3'b000};
  assign m_sml = {1'b1, (swap ? a[9:0] : b[9:0]), 3'b000};
  assign d     = e_big - e_sml;
  assign m_sh  = m_sml >> d;
  assign sum   = {1'b0, m_big} + {1'b0, m_sh};
  assign diff  = m_big - m_sh;

  always_comb begin
    lz    = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && diff[i]) begin
        found = 1'b1;
        lz    = 4'(13 - i);
      end
    end
  end

  assign norm = diff << lz;

  always_comb begin
    res = 16'h0000;
    e_r = e_big;
    if (s_big == s_sml) begin
      if (sum[14]) begin
        e_r = e_big + 5'd1;
        res = {s_big, e_r, sum[13:4]};
      end else begin
        res = {s_big, e_r, sum[12:3]};
      end
    end else if (found) begin
      e_r = e_big - {1'b0, lz};
      res = {s_big, e_r, norm[12:3]};
    end
  end
endmodule

module fp16_stream_accum #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_data,
  output logic [COUNT_W-1:0] out_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OUT = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [15:0]          acc, x_q, add_res;
  logic                 acc_zero, x_valid, x_last, accept;
  logic [COUNT_W-1:0]   cnt;

  fp_adder u_add (.a(acc), .b(x_q), .res(add_res));

  assign in_ready  = (state == RUN) && !(x_valid && x_last);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == OUT);
  assign out_data  = (state == OUT && !acc_zero) ? acc : 16'h0000;
  assign out_count = (state == OUT) ? cnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (x_valid && x_last) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= 16'h0000;
      acc_zero <= 1'b0;
      cnt      <= '0;
      x_q      <= 16'h0000;
      x_last   <= 1'b0;
      x_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          acc      <= 16'h0000;
          acc_zero <= 1'b1;
          cnt      <= '0;
          x_q      <= 16'h0000;
          x_last   <= 1'b0;
          x_valid  <= 1'b0;
        end
        RUN: begin
          x_valid <= accept;
          if (accept) begin
            x_q    <= in_data;
            x_last <= in_last;
            if (cnt != {COUNT_W{1'b1}}) cnt <= cnt + 1'b1;
          end
          // Zero/subnormal operands are skipped so the adder never sees exponent 0.
          if (x_valid && x_q[14:10] != 5'd0) begin
            if (acc_zero) begin
              acc      <= x_q;
              acc_zero <= 1'b0;
            end else begin
              acc <= add_res;
            end
          end
        end
        default: x_valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_stream_accum.sv
// Directed bench for fp16_stream_accum with hand-computed packet sums.
module tb_fp16_stream_accum;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  int          checks = 0;
  int          errors = 0;

  fp16_stream_accum #(.COUNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [15:0] ed, input int ec);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, ed});
    chk({tag, "_cnt"}, {24'd0, out_count}, ec);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_out_count", {24'd0, out_count}, 0);
    @(negedge clk); rst = 1'b0;

    // 1 + 2 + 1 = 4, with explicit 2-cycle latency check
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    send(16'h3C00, 1'b1);
    @(negedge clk);
    chk("lat_not_yet", {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("lat_vld", {31'd0, out_valid}, 1);
    chk("p1_data", {16'd0, out_data}, 32'h4400);
    chk("p1_cnt", {24'd0, out_count}, 3);
    @(posedge clk); #1;

    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b1);
    wait_out("p2", 16'h4200, 2);
    send(16'hC000, 1'b1);
    wait_out("single", 16'hC000, 1);

    send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    wait_out("zeros", 16'h0000, 2);
    send(16'h0000, 1'b0);
    send(16'h4000, 1'b1);
    wait_out("skip", 16'h4000, 2);

    // Backpressure: 2 + 2 = 4, held 5 cycles
    out_ready = 1'b0;
    send(16'h4000, 1'b0);
    send(16'h4000, 1'b1);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", {31'd0, out_valid}, 1);
      chk("bp_data", {16'd0, out_data}, 32'h4400);
      chk("bp_cnt", {24'd0, out_count}, 2);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_vld", {31'd0, out_valid}, 0);
    chk("bp_idle_rdy", {31'd0, in_ready}, 0);
    @(negedge clk);
    chk("bp_run_rdy", {31'd0, in_ready}, 1);

    // Reset mid-packet after 3 of 5 elements
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b0);
    send(16'h3C00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_in_ready", {31'd0, in_ready}, 0);
    chk("mrst_out_valid", {31'd0, out_valid}, 0);
    chk("mrst_out_data", {16'd0, out_data}, 0);
    chk("mrst_out_count", {24'd0, out_count}, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_no_out", {31'd0, out_valid}, 0);
    end
    send(16'h3C00, 1'b1);
    wait_out("post_rst", 16'h3C00, 1);

    // Counter saturation
    for (int i = 0; i < 300; i++) send(16'h0000, i == 299);
    wait_out("sat", 16'h0000, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
